dram_ctrl: RTL and testbench

Initiator-side controller for the team's 16x16 dual-port synchronous DRAM model. It drives one memory port: write enable, read enable, address, write data and the global refresh strobe. A host issues single read/write requests over a valid/ready interface. Periodic refresh is scheduled internally and takes priority over new host requests.

---
 rtl/dram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dram_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// dram_ctrl: host valid/ready requests to one sync-DRAM port with internally scheduled refresh; read data returns 2 edges after accept.
// req_ready is low while a transaction or refresh is in progress or pending; DRAM_CTRL_STATS_EN adds a saturating refresh_cnt output.
module dram_ctrl #(
   parameter int ADDR_W           = 4,
   parameter int DATA_W           = 16,
   parameter int REFRESH_INTERVAL = 64,
   parameter int REFRESH_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_we,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_refresh,
   output logic              refresh_overrun
`ifdef DRAM_CTRL_STATS_EN
   ,
   output logic [15:0]       refresh_cnt
`endif
);

   localparam int TMR_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam int RC_W  = $clog2(REFRESH_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_INTERVAL - 1);
   localparam logic [RC_W-1:0]  RC_LOAD    = RC_W'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CMD, RD_CAP, REFRESH} state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [RC_W-1:0]     rcnt_q, rcnt_d;
   logic                refresh_pending_q, refresh_pending_d;
   logic                overrun_q, overrun_d;
   logic                mem_we_q, mem_we_d;
   logic                mem_en_q, mem_en_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_refresh_q, mem_refresh_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                tmr_tick;
   logic                refresh_enter;

   always_comb begin
      state_d           = state_q;
      rcnt_d            = rcnt_q;
      mem_we_d          = 1'b0;
      mem_en_d          = 1'b0;
      mem_addr_d        = mem_addr_q;
      mem_wdata_d       = mem_wdata_q;
      mem_refresh_d     = 1'b0;
      rsp_valid_d       = 1'b0;
      rsp_rdata_d       = rsp_rdata_q;
      refresh_enter     = 1'b0;
      tmr_tick          = (tmr_q == '0);
      tmr_d             = tmr_tick ? TMR_RELOAD : tmr_q - TMR_W'(1);

      case (state_q)
         IDLE: begin
            if (refresh_pending_q) begin
               refresh_enter = 1'b1;
               mem_refresh_d = 1'b1;
               rcnt_d        = RC_LOAD;
               state_d       = REFRESH;
            end else if (req_valid && req_ready) begin
               mem_addr_d  = req_addr;
               mem_wdata_d = req_wdata;
               mem_we_d    = req_we;
               mem_en_d    = !req_we;
               state_d     = CMD;
            end
         end
         CMD: begin
            state_d = mem_en_q ? RD_CAP : IDLE;
         end
         RD_CAP: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_rdata;
            state_d     = IDLE;
         end
         REFRESH: begin
            if (rcnt_q == '0) begin
               state_d = IDLE;
            end else begin
               rcnt_d        = rcnt_q - RC_W'(1);
               mem_refresh_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new tick outranks the clear on entry; a tick while still pending is an overrun.
      refresh_pending_d = refresh_pending_q;
      if (refresh_enter) refresh_pending_d = 1'b0;
      if (tmr_tick)      refresh_pending_d = 1'b1;
      overrun_d = overrun_q | (tmr_tick & refresh_pending_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         tmr_q             <= TMR_RELOAD;
         rcnt_q            <= '0;
         refresh_pending_q <= 1'b0;
         overrun_q         <= 1'b0;
         mem_we_q          <= 1'b0;
         mem_en_q          <= 1'b0;
         mem_addr_q        <= '0;
         mem_wdata_q       <= '0;
         mem_refresh_q     <= 1'b0;
         rsp_valid_q       <= 1'b0;
         rsp_rdata_q       <= '0;
      end else begin
         state_q           <= state_d;
         tmr_q             <= tmr_d;
         rcnt_q            <= rcnt_d;
         refresh_pending_q <= refresh_pending_d;
         overrun_q         <= overrun_d;
         mem_we_q          <= mem_we_d;
         mem_en_q          <= mem_en_d;
         mem_addr_q        <= mem_addr_d;
         mem_wdata_q       <= mem_wdata_d;
         mem_refresh_q     <= mem_refresh_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_rdata_q       <= rsp_rdata_d;
      end
   end

`ifdef DRAM_CTRL_STATS_EN
   logic [15:0] refresh_cnt_q, refresh_cnt_d;

   always_comb begin
      refresh_cnt_d = refresh_cnt_q;
      if (refresh_enter && refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) refresh_cnt_q <= 16'd0;
      else     refresh_cnt_q <= refresh_cnt_d;
   end

   assign refresh_cnt = refresh_cnt_q;
`endif

   assign req_ready       = (state_q == IDLE) && !refresh_pending_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign mem_we          = mem_we_q;
   assign mem_en          = mem_en_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign mem_refresh     = mem_refresh_q;
   assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: two controllers (refresh interval 64 and 8) each driving a behavioural DRAM,
// checked cycle by cycle against a transaction-level model of acceptance, strobes and refresh slots.
module tb_dram_ctrl;
   localparam int RC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[2];
   logic        req_valid[2], req_ready[2], req_we[2];
   logic [3:0]  req_addr[2];
   logic [15:0] req_wdata[2];
   logic        rsp_valid[2];
   logic [15:0] rsp_rdata[2];
   logic        mem_we[2], mem_en[2], mem_refresh[2], refresh_overrun[2];
   logic [3:0]  mem_addr[2];
   logic [15:0] mem_wdata[2], mem_rdata[2];
`ifdef DRAM_CTRL_STATS_EN
   logic [15:0] refresh_cnt[2];
`endif

   dram_ctrl #(.ADDR_W(4), .DATA_W(16), .REFRESH_INTERVAL(64), .REFRESH_CYCLES(RC)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .mem_we(mem_we[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
      .mem_refresh(mem_refresh[0]), .refresh_overrun(refresh_overrun[0])
`ifdef DRAM_CTRL_STATS_EN
      , .refresh_cnt(refresh_cnt[0])
`endif
   );

   dram_ctrl #(.ADDR_W(4), .DATA_W(16), .REFRESH_INTERVAL(8), .REFRESH_CYCLES(RC)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .mem_we(mem_we[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
      .mem_refresh(mem_refresh[1]), .refresh_overrun(refresh_overrun[1])
`ifdef DRAM_CTRL_STATS_EN
      , .refresh_cnt(refresh_cnt[1])
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int intv(input int i);
      return (i == 0) ? 64 : 8;
   endfunction

   function automatic logic [15:0] init_val(input int i, input int a);
      return 16'((i * 4099 + a * 40503 + 12345) & 16'hFFFF);
   endfunction

   // Behavioural memory: write and read both sampled at the edge, read data registered.
   logic [15:0] mem_arr[2][16];
   initial begin
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 16; a++) mem_arr[i][a] = init_val(i, a);
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (mem_we[i] === 1'b1) mem_arr[i][mem_addr[i]] <= mem_wdata[i];
            if (mem_en[i] === 1'b1) mem_rdata[i] <= mem_arr[i][mem_addr[i]];
         end
      end
   end

   // Reference model: edge index since reset, the first edge at which the controller can take a
   // new decision, refresh owed on every interval multiple, and the expected output values.
   int          m_e[2], m_free[2], m_rsp_at[2], m_ref_lo[2], m_ref_hi[2];
   bit          m_ok[2], m_owed[2], m_ovr[2];
   logic        m_we[2], m_en[2], m_rv[2];
   logic [3:0]  m_addr[2];
   logic [15:0] m_wdata[2], m_rdata[2], m_rd_pend[2], m_rcnt[2];
   logic [15:0] shadow[2][16];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_ok[i] = 1'b0;
         for (int a = 0; a < 16; a++) shadow[i][a] = init_val(i, a);
      end
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
               m_ok[i] = 1'b1; m_e[i] = 0; m_free[i] = 0; m_rsp_at[i] = -1;
               m_ref_lo[i] = -1; m_ref_hi[i] = -2; m_owed[i] = 1'b0; m_ovr[i] = 1'b0;
               m_we[i] = 1'b0; m_en[i] = 1'b0; m_rv[i] = 1'b0; m_addr[i] = '0;
               m_wdata[i] = '0; m_rdata[i] = '0; m_rcnt[i] = '0;
            end else if (m_ok[i]) begin
               m_e[i]++;
               m_we[i] = 1'b0; m_en[i] = 1'b0; m_rv[i] = 1'b0;
               if (m_rsp_at[i] == m_e[i]) begin
                  m_rv[i] = 1'b1;
                  m_rdata[i] = m_rd_pend[i];
               end
               if (m_e[i] >= m_free[i]) begin
                  if (m_owed[i]) begin
                     m_owed[i] = 1'b0;
                     m_ref_lo[i] = m_e[i];
                     m_ref_hi[i] = m_e[i] + RC - 1;
                     m_free[i] = m_e[i] + RC + 1;
                     if (m_rcnt[i] != 16'hFFFF) m_rcnt[i] = m_rcnt[i] + 16'd1;
                  end else if (req_valid[i]) begin
                     m_addr[i] = req_addr[i];
                     m_wdata[i] = req_wdata[i];
                     if (req_we[i]) begin
                        shadow[i][req_addr[i]] = req_wdata[i];
                        m_we[i] = 1'b1;
                        m_free[i] = m_e[i] + 2;
                     end else begin
                        m_en[i] = 1'b1;
                        m_rd_pend[i] = shadow[i][req_addr[i]];
                        m_rsp_at[i] = m_e[i] + 2;
                        m_free[i] = m_e[i] + 3;
                     end
                  end
               end
               if (m_e[i] % intv(i) == 0) begin
                  if (m_owed[i]) m_ovr[i] = 1'b1;
                  m_owed[i] = 1'b1;
               end
            end
         end
      end
   end

   int   bursts[2] = '{0, 0};
   logic prev_ref[2] = '{1'b0, 1'b0};

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (m_ok[i]) begin
               check_val($sformatf("u%0d_mem_we", i), mem_we[i], m_we[i]);
               check_val($sformatf("u%0d_mem_en", i), mem_en[i], m_en[i]);
               check_val($sformatf("u%0d_mem_addr", i), mem_addr[i], m_addr[i]);
               check_val($sformatf("u%0d_mem_wdata", i), mem_wdata[i], m_wdata[i]);
               check_val($sformatf("u%0d_mem_refresh", i), mem_refresh[i],
                         (m_e[i] >= m_ref_lo[i]) && (m_e[i] <= m_ref_hi[i]));
               check_val($sformatf("u%0d_req_ready", i), req_ready[i],
                         (m_e[i] + 1 >= m_free[i]) && !m_owed[i]);
               check_val($sformatf("u%0d_rsp_valid", i), rsp_valid[i], m_rv[i]);
               check_val($sformatf("u%0d_rsp_rdata", i), rsp_rdata[i], m_rdata[i]);
               check_val($sformatf("u%0d_overrun", i), refresh_overrun[i], m_ovr[i]);
`ifdef DRAM_CTRL_STATS_EN
               check_val($sformatf("u%0d_refresh_cnt", i), refresh_cnt[i], m_rcnt[i]);
`endif
               if (mem_refresh[i] === 1'b1 && !prev_ref[i]) bursts[i]++;
               prev_ref[i] = (mem_refresh[i] === 1'b1);
            end
         end
      end
   end

   // Called at a negedge; holds the request until the controller takes it, returns at the negedge after acceptance.
   task automatic do_req(input int i, input logic we, input logic [3:0] a, input logic [15:0] d);
      int n = 0;
      req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
      while (req_ready[i] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("req_accept_timeout", n < 50, 1'b1);
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   task automatic read_expect(input int i, input logic [3:0] a, input logic [15:0] exp);
      int n = 0;
      do_req(i, 1'b0, a, 16'h0000);
      while (rsp_valid[i] !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_val("rd_latency", n, 2);
      check_val("rd_data", rsp_rdata[i], exp);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
         req_addr[i] = '0; req_wdata[i] = '0;
      end
      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Idle through the first refresh slot, then the directed write/read pair.
      repeat (70) @(negedge clk);
      do_req(0, 1'b1, 4'h3, 16'hA5A5);
      check_val("wr_mem_we", mem_we[0], 1'b1);
      check_val("wr_mem_addr", mem_addr[0], 4'h3);
      check_val("wr_mem_wdata", mem_wdata[0], 16'hA5A5);
      @(negedge clk);
      check_val("wr_mem_we_off", mem_we[0], 1'b0);
      check_val("wr_ready_back", req_ready[0], 1'b1);
      read_expect(0, 4'h3, 16'hA5A5);
      do_req(0, 1'b1, 4'h5, 16'h1234);

      // Read accepted on the edge the refresh becomes due: the read completes first.
      while (m_e[0] < 127) @(negedge clk);
      read_expect(0, 4'h3, 16'hA5A5);
      // Request raised just after refresh became pending: refresh runs first.
      while (m_e[0] < 192) @(negedge clk);
      check_val("ready_low_pending", req_ready[0], 1'b0);
      read_expect(0, 4'h5, 16'h1234);

      repeat (300) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      end

      // Reset while the read is in RD_CAP: no response, then normal traffic.
      do_req(0, 1'b0, 4'h7, 16'h0000);
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check_val("rst_no_rsp", rsp_valid[0], 1'b0);
      check_val("rst_mem_addr", mem_addr[0], 4'h0);
      do_req(0, 1'b1, 4'h9, 16'hBEEF);
      read_expect(0, 4'h9, 16'hBEEF);

      // Short refresh interval under back-to-back traffic.
      repeat (100) do_req(1, 1'b0, 4'($urandom_range(0, 15)), 16'($urandom));
      repeat (100) do_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      repeat (4) @(negedge clk);
      check_val("u1_no_overrun", refresh_overrun[1], 1'b0);
      check_val("u1_refreshed", bursts[1] > 40, 1'b1);
`ifdef DRAM_CTRL_STATS_EN
      check_val("u1_stats_vs_bursts", refresh_cnt[1], 16'(bursts[1]));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
